// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv - shared types and constants for the oai221 BIST sequencer
package gf180mcu_fd_sc_mcu7t5v0__bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } bist_state_e;

  localparam int                NPAT          = 32;
  localparam int                IDX_W         = 5;
  localparam logic [IDX_W-1:0]  LAST_IDX      = 5'd31;
  localparam logic [31:0]       DEF_MISR_POLY = 32'h0000_1021;

  // Bit i holds ~((A1|A2)&(B1|B2)&C) for pattern index i = {A1,A2,B1,B2,C}.
  localparam logic [NPAT-1:0]   GOLDEN_LUT    = 32'h5757_57FF;

  function automatic logic golden_exp(input logic [IDX_W-1:0] idx);
    return GOLDEN_LUT[idx];
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_misr.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__bist_misr.sv - serial-input MISR compacting sampled ZN responses
module gf180mcu_fd_sc_mcu7t5v0__bist_misr
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
  parameter int unsigned MISR_W    = 16,
  parameter logic [31:0] MISR_POLY = DEF_MISR_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_bit,
  output logic [MISR_W-1:0] o_sig
);

  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] w_fb;

  assign w_fb  = r_sig[MISR_W-1] ? MISR_POLY[MISR_W-1:0] : '0;
  assign o_sig = r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= {r_sig[MISR_W-2:0], 1'b0} ^ w_fb ^ {{(MISR_W-1){1'b0}}, i_bit};
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai221_bist.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__oai221_bist.sv - oai221 exhaustive BIST sequencer; MISR under GF180MCU_FD_SC_MCU7T5V0_BIST_MISR_EN
module gf180mcu_fd_sc_mcu7t5v0__oai221_bist
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned MISR_W    = 16,
  parameter logic [31:0] MISR_POLY = DEF_MISR_POLY
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              START,
  input  logic              ABORT,
  input  logic              ZN_IN,
  output logic              A1,
  output logic              A2,
  output logic              B1,
  output logic              B2,
  output logic              C,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [IDX_W-1:0]  FAIL_IDX,
  output logic [MISR_W-1:0] SIG
);

  localparam logic [3:0] SETTLE_RLD = 4'(SETTLE - 1);

  bist_state_e      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [3:0]       r_settle;
  logic             r_busy, r_done, r_pass, r_fail;
  logic [IDX_W-1:0] r_fail_idx;
  logic             w_accept, w_abort, w_sample, w_last, w_exp, w_mismatch;

  assign w_exp      = golden_exp(r_cnt);
  // Case equality so an X/Z response is reported as a mismatch in simulation.
  assign w_mismatch = !(ZN_IN === w_exp);

  assign {A1, A2, B1, B2, C} = r_cnt;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign PASS     = r_pass;
  assign FAIL_IDX = r_fail_idx;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_sample    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_nxt = ST_WAIT;
          w_accept    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else if (r_settle == 4'd0) begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_sample = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = ST_FINISH;
            w_last      = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_cnt      <= '0;
      r_settle   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_fail_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt      <= '0;
        r_settle   <= SETTLE_RLD;
        r_busy     <= 1'b1;
        r_pass     <= 1'b0;
        r_fail     <= 1'b0;
        r_fail_idx <= '0;
      end
      if (r_state == ST_WAIT && !w_abort && r_settle != 4'd0) begin
        r_settle <= r_settle - 4'd1;
      end
      if (w_abort) begin
        r_busy <= 1'b0;
        r_pass <= 1'b0;
      end
      if (w_sample) begin
        if (w_mismatch && !r_fail) begin
          r_fail     <= 1'b1;
          r_fail_idx <= r_cnt;
        end
        // Last pattern: stimulus stays on index 31 rather than wrapping.
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= ~(r_fail | w_mismatch);
        end else begin
          r_cnt    <= r_cnt + 5'd1;
          r_settle <= SETTLE_RLD;
        end
      end
    end
  end

`ifdef GF180MCU_FD_SC_MCU7T5V0_BIST_MISR_EN
  gf180mcu_fd_sc_mcu7t5v0__bist_misr #(
    .MISR_W    (MISR_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk   (CLK),
    .rst_n (RN),
    .i_clr (w_accept),
    .i_en  (w_sample),
    .i_bit (ZN_IN),
    .o_sig (SIG)
  );
`else
  // No compaction in this build: the signature is held at zero.
  assign SIG = {MISR_W{1'b0}} & MISR_POLY[MISR_W-1:0];
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai221_bist.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai221_bist.sv - scoreboard bench for the oai221 BIST sequencer
module tb_gf180mcu_fd_sc_mcu7t5v0__oai221_bist;

  typedef struct {
    logic        pass;
    logic [4:0]  idx;
    logic [15:0] sig;
    int          t0;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rn = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, abort0 = 1'b0, abort1 = 1'b0;
  int   mode = 0;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  int   done0_cnt = 0, busy_cnt = 0;
  logic prev_busy = 1'b0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  logic a1_0, a2_0, b1_0, b2_0, c_0, busy0, done0, pass0, zn0;
  logic a1_1, a2_1, b1_1, b2_1, c_1, busy1, done1, pass1, zn1;
  logic [4:0]  fidx0, fidx1;
  logic [15:0] sig0, sig1;
  logic [4:0]  stim0;

  assign stim0 = {a1_0, a2_0, b1_0, b2_0, c_0};
  assign zn0 = (mode == 0) ? ~((a1_0 | a2_0) & (b1_0 | b2_0) & c_0) : (mode == 2);
  assign zn1 = ~((a1_1 | a2_1) & (b1_1 | b2_1) & c_1);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf180mcu_fd_sc_mcu7t5v0__oai221_bist dut0 (
    .CLK(clk), .RN(rn), .START(start0), .ABORT(abort0), .ZN_IN(zn0),
    .A1(a1_0), .A2(a2_0), .B1(b1_0), .B2(b2_0), .C(c_0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_IDX(fidx0), .SIG(sig0)
  );

  gf180mcu_fd_sc_mcu7t5v0__oai221_bist #(.SETTLE(1)) dut1 (
    .CLK(clk), .RN(rn), .START(start1), .ABORT(abort1), .ZN_IN(zn1),
    .A1(a1_1), .A2(a2_1), .B1(b1_1), .B2(b2_1), .C(c_1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_IDX(fidx1), .SIG(sig1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference MISR over the 32 responses an ideal/stuck cell would return.
  function automatic logic [15:0] model_sig(input int m);
    logic [15:0] s;
    logic [4:0]  p;
    logic        zn;
    s = '0;
    for (int i = 0; i < 32; i++) begin
      p  = i[4:0];
      zn = (m == 0) ? ~((p[4] | p[3]) & (p[2] | p[1]) & p[0]) : (m == 2);
      s  = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, zn};
    end
`ifdef GF180MCU_FD_SC_MCU7T5V0_BIST_MISR_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  always @(negedge clk) begin
    if (busy0 && !prev_busy) busy_cnt = 1;
    else if (busy0)          busy_cnt = busy_cnt + 1;
    prev_busy = busy0;
    if (done0) begin
      done0_cnt++;
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_pass", {31'b0, pass0}, {31'b0, e0.pass});
        chk("dut0_fail_idx", {27'b0, fidx0}, {27'b0, e0.idx});
        chk("dut0_sig", {16'b0, sig0}, {16'b0, e0.sig});
        chk("dut0_latency", cyc - e0.t0, e0.lat);
        chk("dut0_busy_cycles", busy_cnt, e0.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_pass", {31'b0, pass1}, {31'b0, e1.pass});
        chk("dut1_fail_idx", {27'b0, fidx1}, {27'b0, e1.idx});
        chk("dut1_sig", {16'b0, sig1}, {16'b0, e1.sig});
        chk("dut1_latency", cyc - e1.t0, e1.lat);
      end
    end
  end

  task automatic run0(output int t0);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    t0 = cyc;
  endtask

  task automatic run1(output int t0);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    t0 = cyc;
  endtask

  task automatic push0(input logic p, input logic [4:0] idx, input int m, input int t0);
    exp_t e;
    e.pass = p; e.idx = idx; e.sig = model_sig(m); e.t0 = t0; e.lat = 96;
    q0.push_back(e);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 500) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    chk("drain_timeout", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, busy0}, 0);
    chk({tag, "_done"}, {31'b0, done0}, 0);
    chk({tag, "_pass"}, {31'b0, pass0}, 0);
    chk({tag, "_fail_idx"}, {27'b0, fidx0}, 0);
    chk({tag, "_stim"}, {27'b0, stim0}, 0);
    chk({tag, "_sig"}, {16'b0, sig0}, 0);
  endtask

  initial begin
    int t, dbefore;
    exp_t e;
    #23;
    chk_zero("reset");
    @(posedge clk); #1 rn = 1'b1;
    repeat (2) @(posedge clk);

    mode = 0; run0(t); push0(1'b1, 5'd0, 0, t);
    wait_drain();
    chk("stim_hold_31", {27'b0, stim0}, 32'h1F);
    chk("pass_held", {31'b0, pass0}, 1);

    mode = 1; run0(t); push0(1'b0, 5'd0, 1, t);
    wait_drain();
    mode = 2; run0(t); push0(1'b0, 5'd11, 2, t);
    wait_drain();

    mode = 0; dbefore = done0_cnt;
    run0(t);
    repeat (39) @(posedge clk);
    #1 abort0 = 1'b1;
    @(posedge clk); #1 abort0 = 1'b0;
    chk("abort_busy", {31'b0, busy0}, 0);
    chk("abort_stim", {27'b0, stim0}, 13);
    chk("abort_pass", {31'b0, pass0}, 0);
    chk("abort_fail_idx", {27'b0, fidx0}, 0);
    repeat (120) @(posedge clk);
    chk("abort_no_done", done0_cnt - dbefore, 0);

    mode = 2;
    run0(t);
    repeat (50) @(posedge clk);
    #3 rn = 1'b0;
    #1 chk_zero("async_reset");
    @(posedge clk); #1 rn = 1'b1;
    @(posedge clk); #1 chk("post_reset_busy", {31'b0, busy0}, 0);

    mode = 0; dbefore = done0_cnt;
    run0(t); push0(1'b1, 5'd0, 0, t);
    repeat (30) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_drain();
    repeat (10) @(posedge clk);
    chk("single_done_after_restart", done0_cnt - dbefore, 1);

    for (int r = 0; r < 2; r++) begin
      run1(t);
      e.pass = 1'b1; e.idx = 5'd0; e.sig = model_sig(0); e.t0 = t; e.lat = 64;
      q1.push_back(e);
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
